// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the count-up stopwatch: FSM encoding,
// BCD digit limits and the packed 4-digit count layout.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RUNNING = 2'd1;
    localparam state_t ST_LAP     = 2'd2;
    localparam state_t ST_STOPPED = 2'd3;

    localparam logic [DIGIT_W-1:0] MAX_MIN     = 4'd9;
    localparam logic [DIGIT_W-1:0] MAX_TEN_SEC = 4'd5;
    localparam logic [DIGIT_W-1:0] MAX_DIGIT   = 4'd9;

    typedef struct packed {
        logic [DIGIT_W-1:0] min;
        logic [DIGIT_W-1:0] ten_sec;
        logic [DIGIT_W-1:0] sec;
        logic [DIGIT_W-1:0] tenths;
    } count_t;

    localparam count_t COUNT_MAX = '{min: MAX_MIN, ten_sec: MAX_TEN_SEC,
                                     sec: MAX_DIGIT, tenths: MAX_DIGIT};

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLK down to a one-cycle tick every DIV enabled cycles; the count
// holds while disabled so a paused stopwatch resumes mid-period.
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic CLK,
    input  logic RST,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int            PW   = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (tick) cnt <= '0;
            else      cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/stopwatch.sv
// Count-up stopwatch with start/stop, lap freeze and clear, saturating at
// 9:59.9. Digits feed display_7_seg as thousands..units = min..tenths.
module stopwatch
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start_stop,
    input  logic       lap_reset,
    output logic [3:0] tenths,
    output logic [3:0] sec,
    output logic [3:0] ten_sec,
    output logic [3:0] min,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    state_t state, state_n;
    count_t count, count_n;
    count_t latch, latch_n;
    count_t shown;
    logic   ovf_n;
    logic   tick;
    logic   at_max;

    function automatic count_t bcd_inc(input count_t c);
        count_t r;
        r = c;
        if (c.tenths != MAX_DIGIT) begin
            r.tenths = c.tenths + 4'd1;
        end else begin
            r.tenths = '0;
            if (c.sec != MAX_DIGIT) begin
                r.sec = c.sec + 4'd1;
            end else begin
                r.sec = '0;
                if (c.ten_sec != MAX_TEN_SEC) begin
                    r.ten_sec = c.ten_sec + 4'd1;
                end else begin
                    r.ten_sec = '0;
                    r.min     = c.min + 4'd1;
                end
            end
        end
        return r;
    endfunction

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .CLK    (CLK),
        .RST    (RST),
        .enable ((state == ST_RUNNING) || (state == ST_LAP)),
        .clear  (state == ST_IDLE),
        .tick   (tick)
    );

    assign at_max = (count == COUNT_MAX);

    always_comb begin
        state_n = state;
        count_n = count;
        latch_n = latch;
        ovf_n   = overflow;
        case (state)
            ST_IDLE: begin
                if (start_stop) state_n = ST_RUNNING;
            end
            ST_RUNNING, ST_LAP: begin
                // Saturation overrides any button seen on the same edge.
                if (tick && at_max) begin
                    ovf_n   = 1'b1;
                    state_n = ST_STOPPED;
                end else begin
                    if (tick) count_n = bcd_inc(count);
                    if (start_stop) begin
                        state_n = ST_STOPPED;
                    end else if (lap_reset) begin
                        if (state == ST_RUNNING) begin
                            state_n = ST_LAP;
                            latch_n = count;
                        end else begin
                            state_n = ST_RUNNING;
                        end
                    end
                end
            end
            ST_STOPPED: begin
                if (start_stop) begin
                    if (!overflow) state_n = ST_RUNNING;
                end else if (lap_reset) begin
                    state_n = ST_IDLE;
                    count_n = '0;
                    latch_n = '0;
                    ovf_n   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            count      <= '0;
            latch      <= '0;
            overflow   <= 1'b0;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            latch      <= latch_n;
            overflow   <= ovf_n;
            running    <= (state_n == ST_RUNNING) || (state_n == ST_LAP);
            lap_active <= (state_n == ST_LAP);
        end
    end

    assign shown   = (state == ST_LAP) ? latch : count;
    assign tenths  = shown.tenths;
    assign sec     = shown.sec;
    assign ten_sec = shown.ten_sec;
    assign min     = shown.min;

endmodule

// File: tb/tb_stopwatch.sv
// Directed bench for stopwatch at CLK_HZ=100, TICK_HZ=10 (one tick per 10
// cycles); display is compared as a packed BCD word {min,ten_sec,sec,tenths}.
module tb_stopwatch;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start_stop;
    logic       lap_reset;
    logic [3:0] tenths, sec, ten_sec, min;
    logic       running, lap_active, overflow;
    logic [15:0] disp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    assign disp = {min, ten_sec, sec, tenths};

    stopwatch #(.CLK_HZ(100), .TICK_HZ(10)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start_stop (start_stop),
        .lap_reset  (lap_reset),
        .tenths     (tenths),
        .sec        (sec),
        .ten_sec    (ten_sec),
        .min        (min),
        .running    (running),
        .lap_active (lap_active),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Pulse the buttons for exactly one rising edge, then sample 1 ns after it.
    task automatic press(input logic ss, input logic lr);
        @(negedge CLK);
        start_stop = ss;
        lap_reset  = lr;
        @(posedge CLK);
        #1;
        start_stop = 1'b0;
        lap_reset  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST        = 1'b1;
        start_stop = 1'b0;
        lap_reset  = 1'b0;
        cycles(3);
        check("rst_disp", 32'(disp), 32'h0000);
        check("rst_running", 32'(running), 32'd0);
        check("rst_lap", 32'(lap_active), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        cycles(2);

        // 1: run 125 cycles, stop, hold, clear
        press(1'b1, 1'b0);
        check("t1_start_running", 32'(running), 32'd1);
        cycles(125);
        check("t1_disp_125", 32'(disp), 32'h0012);
        check("t1_running", 32'(running), 32'd1);
        press(1'b1, 1'b0);
        check("t1_stop_running", 32'(running), 32'd0);
        cycles(50);
        check("t1_hold_50", 32'(disp), 32'h0012);
        press(1'b0, 1'b1);
        check("t1_clear_disp", 32'(disp), 32'h0000);
        check("t1_clear_ovf", 32'(overflow), 32'd0);
        cycles(15);
        check("t1_idle_no_count", 32'(disp), 32'h0000);

        // 2: lap at cycle 35, release at cycle 95
        press(1'b1, 1'b0);
        cycles(34);
        press(1'b0, 1'b1);
        check("t2_lap_disp", 32'(disp), 32'h0003);
        check("t2_lap_active", 32'(lap_active), 32'd1);
        check("t2_lap_running", 32'(running), 32'd1);
        cycles(25);
        check("t2_frozen_60", 32'(disp), 32'h0003);
        cycles(34);
        check("t2_frozen_94", 32'(disp), 32'h0003);
        press(1'b0, 1'b1);
        check("t2_release_disp", 32'(disp), 32'h0009);
        check("t2_release_lap", 32'(lap_active), 32'd0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);

        // 3: stop 4 cycles into a period, resume keeps phase
        press(1'b1, 1'b0);
        cycles(13);
        press(1'b1, 1'b0);
        check("t3_stop_disp", 32'(disp), 32'h0001);
        cycles(100);
        press(1'b1, 1'b0);
        cycles(5);
        check("t3_before_tick", 32'(disp), 32'h0001);
        cycles(1);
        check("t3_tick_at_6", 32'(disp), 32'h0002);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);

        // 4: saturation at 9:59.9
        press(1'b1, 1'b0);
        cycles(59980);
        check("t4_near_max", 32'(disp), 32'h9598);
        cycles(10);
        check("t4_max", 32'(disp), 32'h9599);
        check("t4_max_ovf", 32'(overflow), 32'd0);
        cycles(10);
        check("t4_sat_disp", 32'(disp), 32'h9599);
        check("t4_sat_ovf", 32'(overflow), 32'd1);
        check("t4_sat_running", 32'(running), 32'd0);
        press(1'b1, 1'b0);
        check("t4_start_ignored", 32'(running), 32'd0);
        cycles(20);
        check("t4_still_sat", 32'(disp), 32'h9599);
        press(1'b0, 1'b1);
        check("t4_clear_disp", 32'(disp), 32'h0000);
        check("t4_clear_ovf", 32'(overflow), 32'd0);

        // 5: simultaneous buttons, RUNNING then STOPPED
        press(1'b1, 1'b0);
        cycles(24);
        press(1'b0, 1'b1);
        check("t5_lap_disp", 32'(disp), 32'h0002);
        cycles(4);
        press(1'b0, 1'b1);
        check("t5_unlap_disp", 32'(disp), 32'h0003);
        cycles(4);
        press(1'b1, 1'b1);
        check("t5_both_running", 32'(running), 32'd0);
        check("t5_both_lap", 32'(lap_active), 32'd0);
        cycles(3);
        check("t5_both_disp", 32'(disp), 32'h0003);
        press(1'b1, 1'b1);
        check("t5_resume_running", 32'(running), 32'd1);
        check("t5_resume_lap", 32'(lap_active), 32'd0);
        check("t5_resume_disp", 32'(disp), 32'h0003);
        cycles(4);
        check("t5_before_tick", 32'(disp), 32'h0003);
        cycles(1);
        check("t5_tick", 32'(disp), 32'h0004);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);

        // 6: reset while in LAP
        press(1'b1, 1'b0);
        cycles(244);
        press(1'b0, 1'b1);
        check("t6_lap_disp", 32'(disp), 32'h0024);
        check("t6_lap_active", 32'(lap_active), 32'd1);
        cycles(2);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("t6_rst_disp", 32'(disp), 32'h0000);
        check("t6_rst_running", 32'(running), 32'd0);
        check("t6_rst_lap", 32'(lap_active), 32'd0);
        check("t6_rst_ovf", 32'(overflow), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        press(1'b0, 1'b1);
        check("t6_lr_ignored_lap", 32'(lap_active), 32'd0);
        check("t6_lr_ignored_run", 32'(running), 32'd0);
        cycles(20);
        check("t6_idle_disp", 32'(disp), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
